// File: rtl/rx_fifo_param.sv
// Parametrised single-clock receive FIFO with first-word-fall-through head output,
// occupancy count, almost-full/almost-empty thresholds, flush and sticky error flags.
module rx_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AFULL_TH   = 6,
   parameter int AEMPTY_TH  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       w_enable,
   input  logic [DATA_WIDTH-1:0]      w_data,
   input  logic                       r_enable,
   output logic [DATA_WIDTH-1:0]      r_data,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_empty,
   output logic                       almost_full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
   localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  push, pop;

   assign empty        = (count_q == '0);
   assign full         = (count_q == FULL_C);
   assign almost_empty = (count_q <= AEMPTY_C);
   assign almost_full  = (count_q >= AFULL_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign r_data       = mem_q[rd_ptr_q];

   // A pop frees the slot in the same edge, so a full FIFO still accepts a push alongside it.
   assign push = !flush && w_enable && (!full || r_enable);
   assign pop  = !flush && r_enable && !empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (w_enable && full && !r_enable) overflow_d  = 1'b1;
         if (r_enable && empty)             underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left unreset; reset and flush only touch pointers and count.
   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= w_data;
   end

endmodule

// File: tb/tb_rx_fifo_param.sv
// Self-checking bench for rx_fifo_param: a queue model of the FIFO contents and flags
// is advanced alongside every driven cycle and compared against the DUT.
module tb_rx_fifo_param;

   localparam int DEPTH = 8;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       w_enable;
   logic [7:0] w_data;
   logic       r_enable;
   logic [7:0] r_data;
   logic       empty;
   logic       full;
   logic       almost_empty;
   logic       almost_full;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   logic [7:0] sb_q[$];
   logic       m_ovf;
   logic       m_unf;
   int         n_checks;
   int         n_fails;

   rx_fifo_param #(
      .DATA_WIDTH(8),
      .DEPTH(DEPTH),
      .AFULL_TH(6),
      .AEMPTY_TH(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .w_enable(w_enable),
      .w_data(w_data),
      .r_enable(r_enable),
      .r_data(r_data),
      .empty(empty),
      .full(full),
      .almost_empty(almost_empty),
      .almost_full(almost_full),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of inputs, advances the reference model, and returns 1ns after the edge.
   task automatic tick(input logic w, input logic [7:0] d, input logic r,
                       input logic fl, input logic rs);
      bit m_full;
      bit m_empty;
      rst      = rs;
      flush    = fl;
      w_enable = w;
      w_data   = d;
      r_enable = r;
      m_full   = (sb_q.size() == DEPTH);
      m_empty  = (sb_q.size() == 0);
      if (rs || fl) begin
         sb_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (w && m_full && !r) m_ovf = 1'b1;
         if (r && m_empty)      m_unf = 1'b1;
         if (r && !m_empty)     void'(sb_q.pop_front());
         if (w && (!m_full || r)) sb_q.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
      rst = 1'b0; w_enable = 1'b0; #1;
      n_checks++; if (count !== 4'd0)        begin n_fails++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (empty !== 1'b1)        begin n_fails++; $display("[TB] FAIL reset_empty: got %b want 1", empty); end
      n_checks++; if (full !== 1'b0)         begin n_fails++; $display("[TB] FAIL reset_full: got %b want 0", full); end
      n_checks++; if (almost_empty !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_aempty: got %b want 1", almost_empty); end
      n_checks++; if (almost_full !== 1'b0)  begin n_fails++; $display("[TB] FAIL reset_afull: got %b want 0", almost_full); end
      n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_flags: got %b%b want 00", overflow, underflow); end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= DEPTH; i++) begin
         tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         n_checks++; if (count !== 4'(i)) begin n_fails++; $display("[TB] FAIL fill_count: got %0d want %0d", count, i); end
         n_checks++; if (almost_full !== (i >= 6)) begin n_fails++; $display("[TB] FAIL fill_afull at %0d: got %b", i, almost_full); end
         n_checks++; if (almost_empty !== (i <= 2)) begin n_fails++; $display("[TB] FAIL fill_aempty at %0d: got %b", i, almost_empty); end
         n_checks++; if (full !== (i == DEPTH)) begin n_fails++; $display("[TB] FAIL fill_full at %0d: got %b", i, full); end
      end
      for (int i = 1; i <= DEPTH; i++) begin
         n_checks++; if (r_data !== sb_q[0]) begin n_fails++; $display("[TB] FAIL drain_data: got %h want %h", r_data, sb_q[0]); end
         tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      n_checks++; if (empty !== 1'b1) begin n_fails++; $display("[TB] FAIL drain_empty: got %b want 1", empty); end
      n_checks++; if (underflow !== 1'b0) begin n_fails++; $display("[TB] FAIL drain_underflow: got %b want 0", underflow); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= DEPTH; i++) tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      tick(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      n_checks++; if (overflow !== m_ovf) begin n_fails++; $display("[TB] FAIL ovf_flag: got %b want %b", overflow, m_ovf); end
      n_checks++; if (count !== 4'(sb_q.size())) begin n_fails++; $display("[TB] FAIL ovf_count: got %0d want %0d", count, sb_q.size()); end
      for (int i = 1; i <= DEPTH; i++) begin
         n_checks++; if (r_data !== sb_q[0]) begin n_fails++; $display("[TB] FAIL ovf_drain: got %h want %h", r_data, sb_q[0]); end
         tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      n_checks++; if (empty !== 1'b1) begin n_fails++; $display("[TB] FAIL ovf_empty: got %b want 1", empty); end
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_checks++; if (overflow !== 1'b0) begin n_fails++; $display("[TB] FAIL ovf_flush_clear: got %b want 0", overflow); end
   endtask

   task automatic test_full_simultaneous();
      logic [7:0] last;
      for (int i = 1; i <= DEPTH; i++) tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      n_checks++; if (r_data !== 8'h01) begin n_fails++; $display("[TB] FAIL fsim_head: got %h want 01", r_data); end
      tick(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      n_checks++; if (count !== 4'd8) begin n_fails++; $display("[TB] FAIL fsim_count: got %0d want 8", count); end
      n_checks++; if (overflow !== 1'b0) begin n_fails++; $display("[TB] FAIL fsim_overflow: got %b want 0", overflow); end
      last = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++; if (r_data !== sb_q[0]) begin n_fails++; $display("[TB] FAIL fsim_drain: got %h want %h", r_data, sb_q[0]); end
         last = r_data;
         tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      n_checks++; if (last !== 8'h55) begin n_fails++; $display("[TB] FAIL fsim_last: got %h want 55", last); end
   endtask

   task automatic test_empty_simultaneous();
      tick(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
      n_checks++; if (underflow !== 1'b1) begin n_fails++; $display("[TB] FAIL esim_underflow: got %b want 1", underflow); end
      n_checks++; if (count !== 4'd1) begin n_fails++; $display("[TB] FAIL esim_count: got %0d want 1", count); end
      n_checks++; if (r_data !== 8'h33) begin n_fails++; $display("[TB] FAIL esim_data: got %h want 33", r_data); end
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_checks++; if (underflow !== 1'b0) begin n_fails++; $display("[TB] FAIL esim_flush_clear: got %b want 0", underflow); end
   endtask

   task automatic test_wrap_flush();
      logic w;
      logic r;
      for (int i = 0; i < 32; i++) begin
         w = (($urandom % 4) != 0);
         r = (($urandom % 4) != 0);
         if (r && sb_q.size() != 0) begin
            n_checks++; if (r_data !== sb_q[0]) begin n_fails++; $display("[TB] FAIL wrap_data: got %h want %h", r_data, sb_q[0]); end
         end
         tick(w, 8'($urandom), r, 1'b0, 1'b0);
         n_checks++; if (count !== 4'(sb_q.size())) begin n_fails++; $display("[TB] FAIL wrap_count: got %0d want %0d", count, sb_q.size()); end
         n_checks++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin n_fails++; $display("[TB] FAIL wrap_flags: got %b%b want %b%b", overflow, underflow, m_ovf, m_unf); end
      end
      tick(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      n_checks++; if (count !== 4'd0) begin n_fails++; $display("[TB] FAIL flush_count: got %0d want 0", count); end
      n_checks++; if (empty !== 1'b1) begin n_fails++; $display("[TB] FAIL flush_empty: got %b want 1", empty); end
      n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fails++; $display("[TB] FAIL flush_flags: got %b%b want 00", overflow, underflow); end
      tick(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
      n_checks++; if (r_data !== 8'h99) begin n_fails++; $display("[TB] FAIL flush_discard: got %h want 99", r_data); end
      n_checks++; if (count !== 4'd1) begin n_fails++; $display("[TB] FAIL flush_refill: got %0d want 1", count); end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      rst      = 1'b1;
      flush    = 1'b0;
      w_enable = 1'b0;
      w_data   = 8'h00;
      r_enable = 1'b0;
      $display("[TB] starting rx_fifo_param bench");
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_simultaneous();
      test_empty_simultaneous();
      test_wrap_flush();
      w_enable = 1'b0;
      r_enable = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
